// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer.
//  - 2-bit FSM state encoding (IDLE/RUN/FLUSH/DONE)
//  - default DATA_W, KSIZE and ACC_W constants
package conv_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_KSIZE  = 3;
  localparam int DEF_ACC_W  = 2*DEF_DATA_W + 4;
endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate for the convolution sequencer.
// Optional macro: CONV_SAT_EN -> clamp the accumulator at the signed ACC_W
//   limits and raise a sticky o_sat; otherwise two's-complement wrap, o_sat=0.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_clr           sync clear of accumulator and sticky saturation flag
//   i_en            accumulate i_a*i_b this cycle
//   i_a, i_b        signed DATA_W operands
//   o_acc           ACC_W accumulator value
//   o_sat           sticky saturation indicator
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_sat
);
  localparam int PW = 2*DATA_W;

  logic signed [PW-1:0] w_prod;
  logic [ACC_W-1:0]     w_next;
  logic [ACC_W-1:0]     r_acc;

  assign w_prod = $signed(i_a) * $signed(i_b);

`ifdef CONV_SAT_EN
  // One guard bit detects overflow of the signed sum.
  logic [ACC_W:0] w_sum;
  logic           w_ovf;
  logic           r_sat;

  assign w_sum = {r_acc[ACC_W-1], r_acc} + (ACC_W+1)'(w_prod);
  assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_next = w_sum[ACC_W-1:0];
    if (w_ovf)
      w_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_sat <= 1'b0;
    else if (i_clr) r_sat <= 1'b0;
    else if (i_en && w_ovf) r_sat <= 1'b1;
  end
  assign o_sat = r_sat;
`else
  assign w_next = r_acc + ACC_W'(w_prod);
  assign o_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_next;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/conv_mac_sequencer.sv
// Walks one KSIZE x KSIZE convolution window: issues pixel/weight read
// addresses for one tap per cycle, accumulates returned products, then
// pulses done and holds the result until the next clr or accepted start.
// Optional macro: CONV_SAT_EN (saturating accumulator, sticky sat_flag).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr, start            1-cycle control pulses (clr wins)
//   base_addr             top-left pixel address, latched on accepted start
//   pix_addr, wgt_addr    read addresses (held while rd_en=0)
//   rd_en                 read strobe; data returns one cycle later
//   pix_data, wgt_data    signed read data
//   busy, done            status; done is a 1-cycle pulse
//   result, sat_flag      accumulated sum, sticky saturation flag
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int KSIZE   = DEF_KSIZE,
  parameter int IMG_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int WADDR_W = 4,
  parameter int ACC_W   = 2*DATA_W + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic               rd_en,
  input  logic [DATA_W-1:0]  pix_data,
  input  logic [DATA_W-1:0]  wgt_data,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   result,
  output logic               sat_flag
);
  logic [1:0]         r_state;
  logic [WADDR_W-1:0] r_row, r_col, r_wgt_addr;
  logic [ADDR_W-1:0]  r_row_addr, r_pix_addr;
  logic               r_vld;
  logic [ACC_W-1:0]   r_result;
  logic [ACC_W-1:0]   w_acc;
  logic               w_accept, w_last, w_eol;

  assign w_accept = start & ~clr & (r_state == S_IDLE);
  assign w_eol    = (r_col == WADDR_W'(KSIZE-1));
  assign w_last   = w_eol && (r_row == WADDR_W'(KSIZE-1));

  // r_row_addr tracks base + row*IMG_W so no multiplier or divider is needed;
  // the address registers already hold the current tap while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_row_addr <= '0;
      r_pix_addr <= '0;
      r_wgt_addr <= '0;
      r_vld      <= 1'b0;
      r_result   <= '0;
    end else begin
      r_vld <= ~clr & (r_state == S_RUN);
      if (clr) begin
        r_state  <= S_IDLE;
        r_result <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_state    <= S_RUN;
            r_row      <= '0;
            r_col      <= '0;
            r_row_addr <= base_addr;
            r_pix_addr <= base_addr;
            r_wgt_addr <= '0;
            r_result   <= '0;
          end
          S_RUN: begin
            if (w_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_wgt_addr <= r_wgt_addr + 1'b1;
              if (w_eol) begin
                r_col      <= '0;
                r_row      <= r_row + 1'b1;
                r_row_addr <= r_row_addr + ADDR_W'(IMG_W);
                r_pix_addr <= r_row_addr + ADDR_W'(IMG_W);
              end else begin
                r_col      <= r_col + 1'b1;
                r_pix_addr <= r_pix_addr + 1'b1;
              end
            end
          end
          S_FLUSH: r_state <= S_DONE;
          default: begin
            r_state  <= S_IDLE;
            r_result <= w_acc;
          end
        endcase
      end
    end
  end

  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clr | w_accept),
    .i_en  (r_vld),
    .i_a   (pix_data),
    .i_b   (wgt_data),
    .o_acc (w_acc),
    .o_sat (sat_flag)
  );

  assign pix_addr = r_pix_addr;
  assign wgt_addr = r_wgt_addr;
  assign rd_en    = (r_state == S_RUN);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  // The final sum lands in the accumulator on the FLUSH->DONE edge, so DONE
  // shows it directly; r_result holds it afterwards.
  assign result   = done ? w_acc : r_result;
endmodule

// File: tb/tb_conv_mac_sequencer.sv
module tb_conv_mac_sequencer;
  localparam int DW = 8, K = 3, IW = 8, AW = 8, WAW = 4;
  localparam int ACCA = 2*DW + 4, ACCB = 16;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, start = 1'b0;
  logic [AW-1:0] base_addr = '0;

  logic [AW-1:0] pa_a, pa_b;
  logic [WAW-1:0] wa_a, wa_b;
  logic rd_a, rd_b, busy_a, busy_b, done_a, done_b, sat_a, sat_b;
  logic [DW-1:0] pd_a = '0, wd_a = '0, pd_b = '0, wd_b = '0;
  logic [ACCA-1:0] res_a;
  logic [ACCB-1:0] res_b;

  logic signed [DW-1:0] pmem [256];
  logic signed [DW-1:0] wmem [16];

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  conv_mac_sequencer #(.DATA_W(DW), .KSIZE(K), .IMG_W(IW), .ADDR_W(AW), .WADDR_W(WAW), .ACC_W(ACCA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .base_addr(base_addr),
    .pix_addr(pa_a), .wgt_addr(wa_a), .rd_en(rd_a), .pix_data(pd_a), .wgt_data(wd_a),
    .busy(busy_a), .done(done_a), .result(res_a), .sat_flag(sat_a));

  conv_mac_sequencer #(.DATA_W(DW), .KSIZE(K), .IMG_W(IW), .ADDR_W(AW), .WADDR_W(WAW), .ACC_W(ACCB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .base_addr(base_addr),
    .pix_addr(pa_b), .wgt_addr(wa_b), .rd_en(rd_b), .pix_data(pd_b), .wgt_data(wd_b),
    .busy(busy_b), .done(done_b), .result(res_b), .sat_flag(sat_b));

  // synchronous-read memories, one read port per DUT
  always @(posedge clk) if (rd_a) begin pd_a <= pmem[pa_a]; wd_a <= wmem[wa_a]; end
  always @(posedge clk) if (rd_b) begin pd_b <= pmem[pa_b]; wd_b <= wmem[wa_b]; end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Window sum from the definition: sum of pixel*weight over the kernel,
  // reduced to accw bits after each tap (clamped when saturation is built in).
  function automatic longint model(input int base, input int accw, output bit sat);
    longint acc, mx, mn, md;
    acc = 0; sat = 0;
    mx = (64'sd1 <<< (accw-1)) - 1;
    mn = -(64'sd1 <<< (accw-1));
    md = 64'sd1 <<< accw;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        acc += longint'(pmem[(base + r*IW + c) % 256]) * longint'(wmem[r*K + c]);
`ifdef CONV_SAT_EN
        if (acc > mx) begin acc = mx; sat = 1; end
        else if (acc < mn) begin acc = mn; sat = 1; end
`else
        acc = ((acc % md) + md) % md;
        if (acc > mx) acc -= md;
`endif
      end
    return acc;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++)
      case (mode)
        0: pmem[i] = 8'sd1;
        1: pmem[i] = -8'sd128;
        default: pmem[i] = DW'($urandom);
      endcase
    for (int i = 0; i < 16; i++)
      case (mode)
        0: wmem[i] = 8'sd2;
        1: wmem[i] = 8'sd127;
        default: wmem[i] = DW'($urandom);
      endcase
  endtask

  // One full window; optional stray start pulse mid-run.
  task automatic run_window(input int base, input bit mid_start, input string tag);
    longint e_a, e_b;
    bit s_a, s_b;
    int lat = 0, nbusy = 0, ndone = 0, tap = 0;
    e_a = model(base, ACCA, s_a);
    e_b = model(base, ACCB, s_b);
    @(negedge clk); base_addr = AW'(base); start = 1'b1;
    @(negedge clk); start = 1'b0; base_addr = AW'($urandom);
    for (int k = 1; k <= 16; k++) begin
      if (mid_start) start = (k == 4);
      if (busy_a) nbusy++;
      if (rd_a) begin
        if (tap < K*K) begin
          chk({tag, "_pix"}, pa_a, (base + (tap / K)*IW + tap % K) % 256);
          chk({tag, "_wgt"}, wa_a, tap);
        end
        tap++;
      end
      if (done_a) begin
        ndone++;
        if (lat == 0) lat = k;
        chk({tag, "_res"}, $signed(res_a), e_a);
        chk({tag, "_res16"}, $signed(res_b), e_b);
        chk({tag, "_sat16"}, sat_b, s_b);
        chk({tag, "_sat"}, sat_a, s_a);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, K*K + 2);
    chk({tag, "_busy_cycles"}, nbusy, K*K + 2);
    chk({tag, "_taps"}, tap, K*K);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_hold"}, $signed(res_a), e_a);
  endtask

  initial begin
    fill(0);
    #1;
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0); chk("rst_res", res_a, 0);
    chk("rst_rd", rd_a, 0); chk("rst_pix", pa_a, 0); chk("rst_sat", sat_a, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // 1/2: ones x twos, base 10
    run_window(10, 1'b0, "ones");
    // 3: extreme negative products
    fill(1);
    run_window(40, 1'b0, "neg");
    // random windows, including address wrap near the top
    fill(2);
    run_window(250, 1'b0, "wrap");
    for (int i = 0; i < 4; i++) run_window($urandom_range(0, 255), 1'b0, "rand");
    // 5b: stray start mid-run
    run_window(33, 1'b1, "midstart");

    // 4: clr at tap 4, then a clean window
    @(negedge clk); base_addr = 8'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr_at_tap4", wa_a, 4);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_busy", busy_a, 0); chk("clr_res", res_a, 0); chk("clr_rd", rd_a, 0);
    begin
      int nd = 0;
      for (int k = 0; k < 15; k++) begin if (done_a) nd++; @(negedge clk); end
      chk("clr_nodone", nd, 0);
    end
    run_window(5, 1'b0, "afterclr");

    // 5a: clr and start together from IDLE
    @(negedge clk); clr = 1'b1; start = 1'b1;
    @(negedge clk); clr = 1'b0; start = 1'b0;
    chk("clrstart_busy", busy_a, 0);
    chk("clrstart_res", res_a, 0);
    @(negedge clk);
    chk("clrstart_busy2", busy_a, 0);

    // 6: reset in FLUSH
    @(negedge clk); base_addr = 8'd20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy", busy_a, 1); chk("flush_rd", rd_a, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0); chk("arst_done", done_a, 0); chk("arst_res", res_a, 0);
    chk("arst_pix", pa_a, 0); chk("arst_wgt", wa_a, 0); chk("arst_sat", sat_b, 0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int nd = 0, nb = 0;
      for (int k = 0; k < 15; k++) begin if (done_a) nd++; if (busy_a) nb++; @(negedge clk); end
      chk("arst_nodone", nd, 0);
      chk("arst_idle", nb, 0);
    end
    run_window(100, 1'b0, "afterrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
